fir_decim_round: RTL
====================

FIR_DECIM_ROUND -- requirements
Module: fir_decim_round

Interface
REQ-001 Parameter INPUT_WIDTH, default 26, signed input sample width; equals the upstream FIR filter OUTPUT_WIDTH.
REQ-002 Parameter OUTPUT_WIDTH, default 16, signed output sample width; SHALL be less than INPUT_WIDTH.
REQ-003 Parameter DECIM, default 4, decimation factor; SHALL be at least 1.
REQ-004 Parameter SHIFT, default 10, arithmetic right shift applied before saturation; range 0 to INPUT_WIDTH-1.
REQ-005 Parameter ROUND_MODE, default 1: 0 = truncate, 1 = round-half-up (add 2^(SHIFT-1), then shift).
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 valid_in  input  1  din carries a sample this cycle (driven by FIR valid_out).
REQ-009 din  input  INPUT_WIDTH  signed sample (driven by FIR dout).
REQ-010 sync  input  1  phase realign; the sample accepted this cycle becomes phase 0.
REQ-011 ovf_clr  input  1  clears the sticky overflow flag.
REQ-012 valid_out  output  1  dout holds a new decimated sample; one-cycle pulse per sample.
REQ-013 dout  output  OUTPUT_WIDTH  signed rounded and saturated sample.
REQ-014 ovf  output  1  sticky saturation flag.

Function
REQ-015 Phase counter 0..DECIM-1 SHALL advance only on cycles with valid_in=1 and SHALL wrap from DECIM-1 to 0; cycles with valid_in=0 leave it unchanged.
REQ-016 A sample SHALL be kept only when it arrives at phase 0; all other samples are discarded.
REQ-017 sync=1 together with valid_in=1: that sample SHALL be kept, and the counter SHALL load 1 (or 0 if DECIM=1).
REQ-018 sync=1 with valid_in=0: the counter SHALL load 0, so the next valid sample is kept.
REQ-019 DECIM=1: every valid sample SHALL be kept.
REQ-020 Stage 1 (register): for kept samples, compute din plus the rounding constant in INPUT_WIDTH+1 bits (no wrap), then arithmetic shift right by SHIFT.
REQ-021 With SHIFT=0, the rounding constant SHALL be 0 regardless of ROUND_MODE.
REQ-022 Stage 2 (register): saturate to OUTPUT_WIDTH.
  - Values above 2^(OUTPUT_WIDTH-1)-1 clamp to that maximum.
  - Values below -2^(OUTPUT_WIDTH-1) clamp to that minimum.
REQ-023 Latency SHALL be exactly 2 clk cycles from a kept valid_in to valid_out; throughput is one kept sample per cycle; no backpressure.
REQ-024 dout SHALL hold its last value while valid_out=0.
REQ-025 ovf SHALL set in the same cycle valid_out presents a clamped value, and SHALL remain set until ovf_clr=1.
REQ-026 ovf_clr and a new clamp in the same cycle: set SHALL win, so ovf stays 1.

Reset
REQ-027 On rst=1 at a clock edge, the following SHALL be 0 on the next cycle: phase counter, both stage valids, valid_out, dout, ovf.
REQ-028 rst mid-operation: in-flight samples SHALL be dropped with no valid_out pulse; the first valid sample after rst deasserts is phase 0.
REQ-029 rst SHALL take priority over sync, ovf_clr and valid_in.

Structure
REQ-030 Shared package fir_pkg SHALL hold:
  - round-mode enum round_mode_e (RND_TRUNC=0, RND_HALF_UP=1);
  - the saturation-limit helper functions.
REQ-031 One combinational sub-module, fir_round_sat, SHALL implement the round, shift and saturate datapath, plus a clamp indicator; the pipeline registers stay in fir_decim_round.
REQ-032 Target size: 120-250 RTL lines including the sub-module.

Verification (defaults: IW=26, OW=16, DECIM=4, SHIFT=10, ROUND_MODE=1)
REQ-033 Reset check: hold rst 3 cycles with random din/valid_in.
  - Required: valid_out=0, dout=0, ovf=0 throughout and 1 cycle after release.
REQ-034 Decimation and latency: after reset, din=1024*k for k=1..12 with valid_in continuous.
  - Required: valid_out pulses 2 cycles after k=1, 5 and 9.
  - Required: dout=1, 5, 9.
REQ-035 Rounding: send kept samples din=1535, 1536, -1536, -1537.
  - Required with ROUND_MODE=1: dout=1, 2, -1, -2.
  - Required with ROUND_MODE=0: dout=1, 1, -2, -2.
REQ-036 Saturation and sticky flag, part 1:
  - Kept din=33553920 -> dout=32767 and ovf=1.
  - Then kept din=0 -> dout=0, ovf stays 1.
REQ-037 Saturation and sticky flag, part 2:
  - ovf_clr together with another clamping sample -> ovf stays 1.
  - ovf_clr alone -> ovf=0.
REQ-038 Gaps, sync and reset:
  - valid_in toggling 1/0: only every 4th valid sample is kept.
  - sync with valid_in on sample 2: that sample and sample 6 are kept.
  - rst one cycle after a kept sample: no valid_out follows.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR decimator output stage:
// round-mode encoding, rounding constant and saturation limits.
package fir_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    // Largest signed value representable in 'width' bits.
    function automatic logic signed [63:0] sat_max(input int unsigned width);
        sat_max = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in 'width' bits.
    function automatic logic signed [63:0] sat_min(input int unsigned width);
        sat_min = -(64'sd1 <<< (width - 32'd1));
    endfunction

    // Half an LSB of the shifted result; zero when nothing is shifted out.
    function automatic logic signed [63:0] round_const(input int mode, input int shift);
        if ((mode == int'(RND_HALF_UP)) && (shift > 0)) begin
            round_const = 64'sd1 <<< (shift - 1);
        end else begin
            round_const = 64'sd0;
        end
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational datapath: round and arithmetic-shift one sample, and
// saturate a (separately registered) shifted sample with a clamp flag.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT        = 10,
    parameter int ROUND_MODE   = 1
) (
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic signed [INPUT_WIDTH:0]    shifted,
    input  logic signed [INPUT_WIDTH:0]    sat_in,
    output logic signed [OUTPUT_WIDTH-1:0] sat_out,
    output logic                           clamp
);

    localparam int SW = INPUT_WIDTH + 1;
    localparam logic signed [SW-1:0] RND_C   = SW'(round_const(ROUND_MODE, SHIFT));
    localparam logic signed [SW-1:0] MAX_C   = SW'(sat_max(OUTPUT_WIDTH));
    localparam logic signed [SW-1:0] MIN_C   = SW'(sat_min(OUTPUT_WIDTH));

    logic signed [SW-1:0] sum_s;

    // One extra bit of headroom so adding the rounding constant never wraps.
    always_comb begin
        sum_s   = {din[INPUT_WIDTH-1], din} + RND_C;
        shifted = sum_s >>> SHIFT;
    end

    // Clamp to the output range and flag when clamping occurred.
    always_comb begin
        clamp   = 1'b0;
        sat_out = sat_in[OUTPUT_WIDTH-1:0];
        if (sat_in > MAX_C) begin
            clamp   = 1'b1;
            sat_out = MAX_C[OUTPUT_WIDTH-1:0];
        end else if (sat_in < MIN_C) begin
            clamp   = 1'b1;
            sat_out = MIN_C[OUTPUT_WIDTH-1:0];
        end else begin
            clamp   = 1'b0;
            sat_out = sat_in[OUTPUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_decim_round.sv
// Decimate the FIR output stream by DECIM, then round, shift and saturate
// through a two-stage pipeline with a sticky overflow flag.
module fir_decim_round
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DECIM        = 4,
    parameter int SHIFT        = 10,
    parameter int ROUND_MODE   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    input  logic                           sync,
    input  logic                           ovf_clr,
    output logic                           valid_out,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           ovf
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    // A synced sample is itself phase 0, so the counter moves straight on to 1.
    localparam logic [PW-1:0] PH_SYNC = (DECIM > 1) ? PW'(1) : PW'(0);

    logic [PW-1:0]                  phase_r;
    logic                           keep_s;
    logic                           s1_valid_r;
    logic signed [INPUT_WIDTH:0]    s1_data_r;
    logic signed [INPUT_WIDTH:0]    shifted_s;
    logic signed [OUTPUT_WIDTH-1:0] sat_s;
    logic                           clamp_s;
    logic                           valid_out_r;
    logic signed [OUTPUT_WIDTH-1:0] dout_r;
    logic                           ovf_r;

    fir_round_sat #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .SHIFT       (SHIFT),
        .ROUND_MODE  (ROUND_MODE)
    ) u_round_sat (
        .din    (din),
        .shifted(shifted_s),
        .sat_in (s1_data_r),
        .sat_out(sat_s),
        .clamp  (clamp_s)
    );

    // Keep decision for the sample on din this cycle.
    always_comb begin
        keep_s = valid_in && (sync || (phase_r == PH_ZERO));
    end

    // Decimation phase counter, advanced only by valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= PH_ZERO;
        end else if (sync && valid_in) begin
            phase_r <= PH_SYNC;
        end else if (sync) begin
            phase_r <= PH_ZERO;
        end else if (valid_in) begin
            phase_r <= (phase_r == PH_LAST) ? PH_ZERO : phase_r + PW'(1);
        end else begin
            phase_r <= phase_r;
        end
    end

    // Stage 1: register the rounded and shifted kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= keep_s;
            s1_data_r  <= keep_s ? shifted_s : s1_data_r;
        end
    end

    // Stage 2: register the saturated sample; dout holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_r <= 1'b0;
            dout_r      <= '0;
        end else begin
            valid_out_r <= s1_valid_r;
            dout_r      <= s1_valid_r ? sat_s : dout_r;
        end
    end

    // Sticky overflow; a new clamp beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (s1_valid_r && clamp_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign valid_out = valid_out_r;
    assign dout      = dout_r;
    assign ovf       = ovf_r;

endmodule
